// File: rtl/rounding_arbiter.sv
// Round-robin arbiter feeding one shared round-half-to-even / saturate stage.
// Two registers deep: captured sample + channel, then the tagged output register.
module rounding_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 8,
  parameter int IS_SIGNED = 1,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*WIDTH_IN-1:0] in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_OUT-1:0]       out_data,
  output logic [CH_W-1:0]            out_chan,
  output logic                       out_sat
);

  localparam int D = WIDTH_IN - WIDTH_OUT;
  localparam logic [D-1:0]         HALF = D'(1) << (D - 1);
  localparam logic [WIDTH_OUT-1:0] SMIN = WIDTH_OUT'(1) << (WIDTH_OUT - 1);
  localparam logic [WIDTH_OUT-1:0] SMAX = ~SMIN;

  generate
    if (WIDTH_OUT <= 0 || WIDTH_OUT >= WIDTH_IN) begin : g_bad_width
      $error("rounding_arbiter: WIDTH_OUT must satisfy 0 < WIDTH_OUT < WIDTH_IN");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("rounding_arbiter: NUM_CH must be in 2..16");
    end
  endgenerate

  logic                   s1_valid_reg;
  logic [WIDTH_IN-1:0]    s1_data_reg;
  logic [CH_W-1:0]        s1_chan_reg;
  logic [CH_W-1:0]        ptr_reg;
  logic                   adv;
  logic                   grant_found;
  logic [CH_W-1:0]        grant_idx;
  int                     best_dist;
  int                     cur_dist;
  logic [WIDTH_IN-1:0]    ch_data [NUM_CH];
  logic [WIDTH_OUT-1:0]   rnd_t;
  logic [D-1:0]           rnd_f;
  logic                   rnd_up;
  logic [WIDTH_OUT:0]     rnd_ext;
  logic [WIDTH_OUT:0]     rnd_sum;
  logic [WIDTH_OUT-1:0]   rnd_data;
  logic                   rnd_sat;

  assign adv = !out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*WIDTH_IN +: WIDTH_IN];
      assign in_ready[gi] = adv && grant_found && (grant_idx == CH_W'(gi));
    end
  endgenerate

  // Priority is the distance past the last winner; the nearest requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    best_dist   = NUM_CH;
    cur_dist    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_dist = i - int'(ptr_reg) - 1;
      if (cur_dist < 0) cur_dist = cur_dist + NUM_CH;
      if (in_valid[i] && cur_dist < best_dist) begin
        best_dist   = cur_dist;
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  assign rnd_t  = s1_data_reg[WIDTH_IN-1:D];
  assign rnd_f  = s1_data_reg[D-1:0];
  assign rnd_up = (rnd_f > HALF) || ((rnd_f == HALF) && rnd_t[0]);

  // One extra bit of headroom catches the carry out of the round-up.
  always_comb begin
    rnd_ext = {1'b0, rnd_t};
    if (IS_SIGNED != 0) rnd_ext = {rnd_t[WIDTH_OUT-1], rnd_t};
    rnd_sum  = rnd_ext + {{WIDTH_OUT{1'b0}}, rnd_up};
    rnd_data = rnd_sum[WIDTH_OUT-1:0];
    rnd_sat  = 1'b0;
    if (IS_SIGNED != 0) begin
      if (rnd_sum[WIDTH_OUT] != rnd_sum[WIDTH_OUT-1]) begin
        rnd_sat  = 1'b1;
        rnd_data = rnd_sum[WIDTH_OUT] ? SMIN : SMAX;
      end
    end else if (rnd_sum[WIDTH_OUT]) begin
      rnd_sat  = 1'b1;
      rnd_data = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_chan_reg  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_chan     <= '0;
      out_sat      <= 1'b0;
      ptr_reg      <= CH_W'(NUM_CH - 1);
    end else if (adv) begin
      out_valid    <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data <= rnd_data;
        out_chan <= s1_chan_reg;
        out_sat  <= rnd_sat;
      end
      s1_valid_reg <= grant_found;
      if (grant_found) begin
        s1_data_reg <= ch_data[grant_idx];
        s1_chan_reg <= grant_idx;
        ptr_reg     <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_rounding_arbiter.sv
// Scoreboarded bench: a signed and an unsigned instance share stimulus; a negedge
// monitor models arbitration and rounding arithmetically and checks every output.
module tb_rounding_arbiter;
  localparam int NCH  = 4;
  localparam int WIN  = 16;
  localparam int WOUT = 8;
  localparam int CW   = 2;

  typedef struct packed {
    logic [31:0]     cyc;
    logic [WOUT-1:0] data;
    logic [CW-1:0]   chan;
    logic            sat;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH*WIN-1:0] in_data = '0;
  logic out_ready = 1'b1;
  logic [NCH-1:0] in_ready, in_ready_u;
  logic out_valid, out_valid_u, out_sat, out_sat_u;
  logic [WOUT-1:0] out_data, out_data_u;
  logic [CW-1:0] out_chan, out_chan_u;

  int checks = 0;
  int failures = 0;
  item_t sb_q[$], sbu_q[$], obs_q[$], obsu_q[$];
  int grant_log[$];
  int last_grant = NCH - 1;
  int cyc = 0;
  bit exact_lat = 1'b0;
  bit prev_hold = 1'b0;
  logic [WOUT-1:0] prev_data;
  logic [CW-1:0] prev_chan;
  logic prev_sat;
  int g, lat;
  logic [NCH-1:0] exp_ready;
  logic adv_exp;
  item_t e, o;
  logic [WOUT-1:0] d;
  logic s;

  logic [WIN-1:0]  t1_in  [5] = '{16'h0280, 16'h0380, 16'h0281, 16'hFE80, 16'hFF7F};
  logic [WOUT-1:0] t1_out [5] = '{8'h02, 8'h04, 8'h03, 8'hFE, 8'hFF};
  logic [WIN-1:0]  sat_in [3] = '{16'h7FFF, 16'h7F7F, 16'hFFFF};

  rounding_arbiter #(.NUM_CH(NCH), .WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .IS_SIGNED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_sat(out_sat));

  rounding_arbiter #(.NUM_CH(NCH), .WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .IS_SIGNED(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_u),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_chan(out_chan_u),
    .out_sat(out_sat_u));

  always #5 clk = ~clk;

  // Reference rounding: floor-divide, round half to even, clamp to the output range.
  function automatic void ref_round(input logic [WIN-1:0] x, input bit sgn,
                                    output logic [WOUT-1:0] rd, output logic rs);
    longint v, q, rem, scale, lo, hi;
    scale = longint'(1) << (WIN - WOUT);
    v = sgn ? longint'($signed(x)) : longint'(x);
    q = v / scale;
    if ((v % scale) != 0 && v < 0) q = q - 1;
    rem = v - q * scale;
    if (rem * 2 > scale || (rem * 2 == scale && (q % 2) != 0)) q = q + 1;
    hi = sgn ? (longint'(1) << (WOUT - 1)) - 1 : (longint'(1) << WOUT) - 1;
    lo = sgn ? -(longint'(1) << (WOUT - 1)) : 0;
    rs = 1'b0;
    if (q > hi) begin q = hi; rs = 1'b1; end
    else if (q < lo) begin q = lo; rs = 1'b1; end
    rd = WOUT'(q);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      sbu_q.delete();
      last_grant = NCH - 1;
      prev_hold = 1'b0;
    end else begin
      cyc++;
      if (prev_hold) begin
        checks++;
        if (!out_valid || out_data !== prev_data || out_chan !== prev_chan || out_sat !== prev_sat) begin
          failures++;
          $display("FAIL hold_stable: got v=%0b d=%h c=%0d s=%0b, required v=1 d=%h c=%0d s=%0b",
                   out_valid, out_data, out_chan, out_sat, prev_data, prev_chan, prev_sat);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_chan = out_chan;
      prev_sat  = out_sat;

      adv_exp = !out_valid || out_ready;
      g = -1;
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && in_valid[CW'((last_grant + k) % NCH)]) g = (last_grant + k) % NCH;
      exp_ready = '0;
      if (adv_exp && g >= 0) exp_ready[CW'(g)] = 1'b1;
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL in_ready: got %b, required %b (cycle %0d)", in_ready, exp_ready, cyc);
      end
      checks++;
      if (in_ready_u !== exp_ready) begin
        failures++;
        $display("FAIL in_ready_u: got %b, required %b (cycle %0d)", in_ready_u, exp_ready, cyc);
      end

      if (out_valid && out_ready) begin
        o.cyc = 32'(cyc); o.data = out_data; o.chan = out_chan; o.sat = out_sat;
        obs_q.push_back(o);
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL out_signed: got unexpected result d=%h c=%0d, required none", out_data, out_chan);
        end else begin
          e = sb_q.pop_front();
          lat = cyc - int'(e.cyc);
          if (out_data !== e.data || out_chan !== e.chan || out_sat !== e.sat ||
              lat < 2 || (exact_lat && lat != 2)) begin
            failures++;
            $display("FAIL out_signed: got d=%h c=%0d s=%0b lat=%0d, required d=%h c=%0d s=%0b lat=2",
                     out_data, out_chan, out_sat, lat, e.data, e.chan, e.sat);
          end
        end
      end
      if (out_valid_u && out_ready) begin
        o.cyc = 32'(cyc); o.data = out_data_u; o.chan = out_chan_u; o.sat = out_sat_u;
        obsu_q.push_back(o);
        checks++;
        if (sbu_q.size() == 0) begin
          failures++;
          $display("FAIL out_unsigned: got unexpected result d=%h c=%0d, required none", out_data_u, out_chan_u);
        end else begin
          e = sbu_q.pop_front();
          if (out_data_u !== e.data || out_chan_u !== e.chan || out_sat_u !== e.sat) begin
            failures++;
            $display("FAIL out_unsigned: got d=%h c=%0d s=%0b, required d=%h c=%0d s=%0b",
                     out_data_u, out_chan_u, out_sat_u, e.data, e.chan, e.sat);
          end
        end
      end

      if (adv_exp && g >= 0) begin
        ref_round(WIN'(in_data >> (g * WIN)), 1'b1, d, s);
        e.cyc = 32'(cyc); e.data = d; e.chan = CW'(g); e.sat = s;
        sb_q.push_back(e);
        ref_round(WIN'(in_data >> (g * WIN)), 1'b0, d, s);
        e.data = d; e.sat = s;
        sbu_q.push_back(e);
        last_grant = g;
        grant_log.push_back(g);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIN-1:0] v);
    in_data[ch*WIN +: WIN] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_obs(input int target, input string nm);
    int n;
    n = 0;
    while (obs_q.size() < target && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (obs_q.size() < target) begin
      failures++;
      $display("FAIL %s timeout: got %0d results, required %0d", nm, obs_q.size(), target);
    end
  endtask

  task automatic expect_obs(input bit uns, input int idx, input logic [WOUT-1:0] xd,
                            input logic [CW-1:0] xc, input logic xs, input string nm);
    item_t it;
    checks++;
    if (idx >= (uns ? obsu_q.size() : obs_q.size())) begin
      failures++;
      $display("FAIL %s: got no result %0d, required d=%h c=%0d s=%0b", nm, idx, xd, xc, xs);
    end else begin
      it = uns ? obsu_q[idx] : obs_q[idx];
      if (it.data !== xd || it.chan !== xc || it.sat !== xs) begin
        failures++;
        $display("FAIL %s[%0d]: got d=%h c=%0d s=%0b, required d=%h c=%0d s=%0b",
                 nm, idx, it.data, it.chan, it.sat, xd, xc, xs);
      end
    end
  endtask

  task automatic expect_grant(input int idx, input int xg, input string nm);
    checks++;
    if (idx >= grant_log.size()) begin
      failures++;
      $display("FAIL %s: got no grant %0d, required %0d", nm, idx, xg);
    end else if (grant_log[idx] != xg) begin
      failures++;
      $display("FAIL %s[%0d]: got grant %0d, required %0d", nm, idx, grant_log[idx], xg);
    end
  endtask

  task automatic check_bit(input logic act, input logic req, input string nm);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, required %b", nm, act, req);
    end
  endtask

  initial begin
    int base;
    int bg;
    repeat (3) step();
    check_bit(out_valid, 1'b0, "reset_out_valid");
    check_bit(out_valid_u, 1'b0, "reset_out_valid_u");
    check_bit(out_sat, 1'b0, "reset_out_sat");
    check_bit(out_data == 8'h00, 1'b1, "reset_out_data_zero");
    check_bit(out_chan == 2'd0, 1'b1, "reset_out_chan_zero");
    rst_n = 1'b1;

    // Channel 0 rounding sequence, exact two-cycle latency
    exact_lat = 1'b1;
    base = obs_q.size();
    in_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin set_ch(0, t1_in[i]); step(); end
    in_valid = '0;
    wait_obs(base + 5, "ch0_seq");
    for (int i = 0; i < 5; i++) expect_obs(1'b0, base + i, t1_out[i], 2'd0, 1'b0, "ch0_round");

    // Saturation corners
    base = obs_q.size();
    in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin set_ch(0, sat_in[i]); step(); end
    in_valid = '0;
    wait_obs(base + 3, "sat_seq");
    expect_obs(1'b0, base + 0, 8'h7F, 2'd0, 1'b1, "sat_s_7fff");
    expect_obs(1'b0, base + 1, 8'h7F, 2'd0, 1'b0, "sat_s_7f7f");
    expect_obs(1'b0, base + 2, 8'h00, 2'd0, 1'b0, "sat_s_ffff");
    expect_obs(1'b1, base + 0, 8'h80, 2'd0, 1'b0, "sat_u_7fff");
    expect_obs(1'b1, base + 2, 8'hFF, 2'd0, 1'b1, "sat_u_ffff");

    // Full rotation from reset
    do_reset();
    base = obs_q.size();
    in_valid = 4'b1111;
    for (int c = 0; c < NCH; c++) set_ch(c, WIN'(c * 256));
    repeat (6) step();
    in_valid = '0;
    wait_obs(base + 6, "rotation");
    for (int i = 0; i < 6; i++) expect_obs(1'b0, base + i, WOUT'(i % NCH), CW'(i % NCH), 1'b0, "rotation");

    // Backpressure with two results in flight
    exact_lat = 1'b0;
    base = obs_q.size();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    set_ch(0, 16'h0500); step();
    set_ch(0, 16'h0600); step();
    set_ch(0, 16'h0700);
    for (int i = 0; i < 5; i++) begin
      check_bit(out_valid, 1'b1, "stall_out_valid");
      check_bit(out_data == 8'h05, 1'b1, "stall_out_data_05");
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = '0;
    wait_obs(base + 3, "stall_drain");
    expect_obs(1'b0, base + 0, 8'h05, 2'd0, 1'b0, "stall_order");
    expect_obs(1'b0, base + 1, 8'h06, 2'd0, 1'b0, "stall_order");
    expect_obs(1'b0, base + 2, 8'h07, 2'd0, 1'b0, "stall_order");

    // Sparse requesters and a late channel-2 request
    base = obs_q.size();
    bg = grant_log.size();
    in_valid = 4'b0010; step();
    in_valid = 4'b1010; step(); step();
    in_valid = 4'b1110; step(); step();
    in_valid = '0;
    wait_obs(base + 5, "arb_drain");
    expect_grant(bg + 0, 1, "arb_order");
    expect_grant(bg + 1, 3, "arb_order");
    expect_grant(bg + 2, 1, "arb_order");
    expect_grant(bg + 3, 2, "arb_order");
    expect_grant(bg + 4, 3, "arb_order");

    // Asynchronous reset with data in flight
    in_valid = 4'b0001;
    set_ch(0, 16'h0900); step();
    set_ch(0, 16'h0A00); step();
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check_bit(out_valid, 1'b0, "async_rst_out_valid");
    check_bit(out_valid_u, 1'b0, "async_rst_out_valid_u");
    step();
    step();
    base = obs_q.size();
    bg = grant_log.size();
    for (int c = 0; c < NCH; c++) set_ch(c, WIN'(16'h0B00 + c * 256));
    in_valid = 4'b1111;
    rst_n = 1'b1;
    step();
    in_valid = '0;
    repeat (4) step();
    expect_grant(bg, 0, "post_reset_grant");
    check_bit(obs_q.size() == base + 1, 1'b1, "post_reset_single_result");
    expect_obs(1'b0, base, 8'h0B, 2'd0, 1'b0, "post_reset_result");

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = NCH'($urandom_range(0, 15));
      in_data = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (6) step();
    check_bit(sb_q.size() == 0, 1'b1, "drain_empty_signed");
    check_bit(sbu_q.size() == 0, 1'b1, "drain_empty_unsigned");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
